// File: rtl/spi_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
// Shared constants for the SPI sample receiver:
//   - default sample / address widths
//   - SPI mode encoding, packed as {CPOL, CPHA}
//   - helper telling whether a mode samples on the rising sclk edge
// -----------------------------------------------------------------------------
package spi_rx_pkg;

  localparam int DATA_W_DEFAULT = 12;
  localparam int ADDR_W_DEFAULT = 16;

  // SPI mode encoding, index = {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

  // Modes 0 and 3 capture on the rising sclk edge, modes 1 and 2 on falling.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return (mode[1] ^ mode[0]) == 1'b0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   push, push_data  : write request and data; accepted when not full, or
//                      when full together with a pop in the same cycle
//   pop              : consume the head entry (ignored when empty)
//   pop_data         : head entry, zero while empty
//   empty, full      : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags, accepted transfers and the head entry.
  always_comb begin
    empty     = (count_r == {CW{1'b0}});
    full      = (count_r == DEPTH_C);
    do_pop_s  = pop & ~empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    do_push_s = push & (~full | do_pop_s);
    if (empty) begin
      pop_data = {WIDTH{1'b0}};
    end else begin
      pop_data = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_sample_rx.sv
// -----------------------------------------------------------------------------
// spi_sample_rx
// SPI slave receiver that packs MSB-first bytes into a little-endian bit
// stream of DATA_W-bit samples, tags each sample with a per-frame address and
// queues them in a FWFT FIFO.
// Ports:
//   clk, rstn               : system clock, asynchronous active-low reset
//   sclk, mosi, cs_n        : SPI slave pins (asynchronous to clk)
//   miso                    : tied low
//   out_valid/out_ready     : sample stream handshake
//   out_data, out_addr      : head sample and its address
//   overflow                : sticky, set when a sample is dropped on a full
//                             FIFO; cleared at frame start
// -----------------------------------------------------------------------------
module spi_sample_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              overflow
);

  localparam logic       CPOL_B = 1'(CPOL);
  localparam logic       CPHA_B = 1'(CPHA);
  localparam logic [1:0] MODE   = {CPOL_B, CPHA_B};
  localparam int         ACC_W  = DATA_W + 7;
  localparam int         FILL_W = 6;
  localparam int         FIFO_W = DATA_W + ADDR_W;
  localparam logic [FILL_W-1:0] DATA_W_F = FILL_W'(DATA_W);
  localparam logic [FILL_W-1:0] BYTE_F   = 6'd8;

  // Synchronisers: bit 0 is the metastability flop, bit 1 the usable copy.
  logic [1:0] sclk_sync_r;
  logic [1:0] mosi_sync_r;
  logic [1:0] cs_sync_r;
  logic       sclk_s;
  logic       mosi_s;
  logic       cs_s;

  logic       sclk_prev_r;
  logic       cs_prev_r;
  logic [1:0] sync_ready_r;
  logic       armed_r;
  logic       frame_r;

  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       sample_edge_s;
  logic       cs_fall_s;
  logic       cs_rise_s;
  logic       bit_edge_s;

  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       byte_stb_r;

  logic [ACC_W-1:0]  acc_r;
  logic [FILL_W-1:0] fill_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ACC_W-1:0]  acc_or_s;
  logic [FILL_W-1:0] fill_sum_s;
  logic              emit_s;

  logic              push_r;
  logic [DATA_W-1:0] push_data_r;
  logic [ADDR_W-1:0] push_addr_r;
  logic              overflow_r;

  logic              pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [FIFO_W-1:0] fifo_head_s;

  // Two-flop synchronisers for the SPI pins; reset values match idle levels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_r <= {2{CPOL_B}};
      mosi_sync_r <= 2'b00;
      cs_sync_r   <= 2'b11;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      cs_sync_r   <= {cs_sync_r[0], cs_n};
    end
  end

  assign sclk_s = sclk_sync_r[1];
  assign mosi_s = mosi_sync_r[1];
  assign cs_s   = cs_sync_r[1];

  // Edge history and frame tracking.
  // armed_r is only set once the synchroniser carries the real pin level and
  // cs_n has been seen high; this keeps a reset released mid-frame from
  // mistaking the synchroniser's 1->0 flush for a frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_prev_r  <= CPOL_B;
      cs_prev_r    <= 1'b1;
      sync_ready_r <= 2'b00;
      armed_r      <= 1'b0;
      frame_r      <= 1'b0;
    end else begin
      sclk_prev_r  <= sclk_s;
      cs_prev_r    <= cs_s;
      sync_ready_r <= {sync_ready_r[0], 1'b1};
      armed_r      <= armed_r | (sync_ready_r[1] & cs_s);
      if (cs_fall_s) begin
        frame_r <= 1'b1;
      end else if (cs_rise_s) begin
        frame_r <= 1'b0;
      end else begin
        frame_r <= frame_r;
      end
    end
  end

  // Edge decode and selection of the capture edge for this SPI mode.
  always_comb begin
    sclk_rise_s = sclk_s & ~sclk_prev_r;
    sclk_fall_s = ~sclk_s & sclk_prev_r;
    case (MODE)
      SPI_MODE_0, SPI_MODE_3: sample_edge_s = sclk_rise_s;
      SPI_MODE_1, SPI_MODE_2: sample_edge_s = sclk_fall_s;
      default:                sample_edge_s = 1'b0;
    endcase
    if (!sample_on_rise(MODE)) begin
      sample_edge_s = sclk_fall_s;
    end else begin
      sample_edge_s = sclk_rise_s;
    end
    cs_fall_s  = cs_prev_r & ~cs_s & armed_r;
    cs_rise_s  = ~cs_prev_r & cs_s;
    bit_edge_s = sample_edge_s & frame_r & ~cs_s;
  end

  // Byte assembly: MSB-first shift, 3-bit counter, strobe after the 8th bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      byte_stb_r <= 1'b0;
    end else begin
      byte_stb_r <= bit_edge_s && (bit_cnt_r == 3'd7);
      if (cs_fall_s || cs_rise_s) begin
        // Any partial byte is abandoned at a frame boundary.
        bit_cnt_r <= 3'd0;
      end else if (bit_edge_s) begin
        shift_r   <= {shift_r[6:0], mosi_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Packer datapath: merge the new byte above the bits already held.
  always_comb begin
    acc_or_s   = acc_r | (ACC_W'(shift_r) << fill_r);
    fill_sum_s = fill_r + BYTE_F;
    if (byte_stb_r && (fill_sum_s >= DATA_W_F)) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
  end

  // Packer state, sample address and the registered FIFO write.
  // A strobe coincident with frame end is still packed (and may emit);
  // only the leftover partial sample is then discarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r       <= {ACC_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      push_r      <= 1'b0;
      push_data_r <= {DATA_W{1'b0}};
      push_addr_r <= {ADDR_W{1'b0}};
    end else begin
      push_r <= emit_s;
      if (emit_s) begin
        push_data_r <= acc_or_s[DATA_W-1:0];
        push_addr_r <= addr_r;
      end
      if (cs_fall_s) begin
        acc_r  <= {ACC_W{1'b0}};
        fill_r <= {FILL_W{1'b0}};
        addr_r <= {ADDR_W{1'b0}};
      end else begin
        if (byte_stb_r) begin
          if (emit_s) begin
            acc_r  <= acc_or_s >> DATA_W;
            fill_r <= fill_sum_s - DATA_W_F;
            // Address advances even if the FIFO later drops this sample.
            addr_r <= addr_r + ADDR_W'(1);
          end else begin
            acc_r  <= acc_or_s;
            fill_r <= fill_sum_s;
          end
        end
        if (cs_rise_s) begin
          acc_r  <= {ACC_W{1'b0}};
          fill_r <= {FILL_W{1'b0}};
        end
      end
    end
  end

  assign pop_s = ~fifo_empty_s & out_ready;

  // Sticky overflow: a push refused because the FIFO is full and not popping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_r <= 1'b0;
    end else if (cs_fall_s) begin
      overflow_r <= 1'b0;
    end else if (push_r && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_r),
    .push_data ({push_addr_r, push_data_r}),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign out_valid = ~fifo_empty_s;
  assign out_data  = fifo_head_s[DATA_W-1:0];
  assign out_addr  = fifo_head_s[FIFO_W-1:DATA_W];
  assign overflow  = overflow_r;
  assign miso      = 1'b0;

endmodule

// File: tb/tb_spi_sample_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_sample_rx
// Directed bench for spi_sample_rx. dut0: DATA_W=12, mode 0. dut1: DATA_W=16,
// CPOL=1, CPHA=1. A monitor records every accepted output transfer; tests
// compare those records against hand-computed samples.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_sample_rx;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rstn;

  logic        sclk0, mosi0, cs0, ready0;
  logic        miso0, valid0, ovf0;
  logic [11:0] data0;
  logic [15:0] addr0;

  logic        sclk1, mosi1, cs1, ready1;
  logic        miso1, valid1, ovf1;
  logic [15:0] data1;
  logic [15:0] addr1;

  logic [31:0] q0d[$], q0a[$], q1d[$], q1a[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_sample_rx #(.DATA_W(12), .ADDR_W(16), .CPOL(0), .CPHA(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rstn(rstn), .sclk(sclk0), .mosi(mosi0), .cs_n(cs0), .miso(miso0),
    .out_valid(valid0), .out_ready(ready0), .out_data(data0), .out_addr(addr0),
    .overflow(ovf0)
  );

  spi_sample_rx #(.DATA_W(16), .ADDR_W(16), .CPOL(1), .CPHA(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rstn(rstn), .sclk(sclk1), .mosi(mosi1), .cs_n(cs1), .miso(miso1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_addr(addr1),
    .overflow(ovf1)
  );

  // Record each transfer that will be accepted on the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (valid0 && ready0) begin
      q0d.push_back(32'(data0));
      q0a.push_back(32'(addr0));
    end
    if (valid1 && ready1) begin
      q1d.push_back(32'(data1));
      q1a.push_back(32'(addr1));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift the top nbits of val, MSB first. dev 0 is mode 0, dev 1 is mode 3.
  task automatic spi_bits(input int dev, input logic [7:0] val, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (dev == 0) begin
        mosi0 = val[i];
        wait_clk(HALF);
        sclk0 = 1'b1;
        wait_clk(HALF);
        sclk0 = 1'b0;
      end else begin
        sclk1 = 1'b0;
        mosi1 = val[i];
        wait_clk(HALF);
        sclk1 = 1'b1;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic send_byte(input int dev, input logic [7:0] val);
    spi_bits(dev, val, 8);
  endtask

  task automatic cs_set(input int dev, input logic v);
    if (dev == 0) cs0 = v;
    else          cs1 = v;
    wait_clk(2 * HALF);
  endtask

  task automatic expect_entry(input string tag, input int dev, input int idx,
                              input logic [31:0] ed, input logic [31:0] ea);
    logic [31:0] d;
    logic [31:0] a;
    d = 32'hFFFF_FFFF;
    a = 32'hFFFF_FFFF;
    if (dev == 0) begin
      if (idx < q0d.size()) begin
        d = q0d[idx];
        a = q0a[idx];
      end
    end else begin
      if (idx < q1d.size()) begin
        d = q1d[idx];
        a = q1a[idx];
      end
    end
    check($sformatf("%s_data%0d", tag, idx), d, ed);
    check($sformatf("%s_addr%0d", tag, idx), a, ea);
  endtask

  task automatic clear_q0();
    q0d.delete();
    q0a.delete();
  endtask

  initial begin
    logic seen;

    rstn = 1'b0;
    sclk0 = 1'b0; mosi0 = 1'b0; cs0 = 1'b1; ready0 = 1'b0;
    sclk1 = 1'b1; mosi1 = 1'b0; cs1 = 1'b1; ready1 = 1'b0;
    wait_clk(4);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_data0", 32'(data0), 32'd0);
    check("rst_addr0", 32'(addr0), 32'd0);
    check("rst_ovf0", 32'(ovf0), 32'd0);
    check("rst_miso0", 32'(miso0), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    rstn = 1'b1;
    wait_clk(10);

    // Test 1: 12-bit, mode 0
    ready0 = 1'b1;
    cs_set(0, 1'b0);
    send_byte(0, 8'h21); send_byte(0, 8'h43); send_byte(0, 8'h65);
    cs_set(0, 1'b1);
    wait_clk(20);
    check("t1_count", 32'(q0d.size()), 32'd2);
    expect_entry("t1", 0, 0, 32'h321, 32'd0);
    expect_entry("t1", 0, 1, 32'h654, 32'd1);
    check("t1_ovf", 32'(ovf0), 32'd0);
    check("t1_miso", 32'(miso0), 32'd0);

    // Test 2: 16-bit, CPOL=1 CPHA=1
    ready1 = 1'b1;
    cs_set(1, 1'b0);
    send_byte(1, 8'h34); send_byte(1, 8'h12); send_byte(1, 8'h78); send_byte(1, 8'h56);
    cs_set(1, 1'b1);
    wait_clk(20);
    check("t2_count", 32'(q1d.size()), 32'd2);
    expect_entry("t2", 1, 0, 32'h1234, 32'd0);
    expect_entry("t2", 1, 1, 32'h5678, 32'd1);
    check("t2_ovf", 32'(ovf1), 32'd0);

    // Test 3: overflow with out_ready low, 9 bytes -> 6 samples, 4 kept
    clear_q0();
    ready0 = 1'b0;
    cs_set(0, 1'b0);
    for (int b = 1; b <= 9; b++) send_byte(0, 8'(b));
    cs_set(0, 1'b1);
    wait_clk(20);
    check("t3_none_yet", 32'(q0d.size()), 32'd0);
    check("t3_valid", 32'(valid0), 32'd1);
    check("t3_head_data", 32'(data0), 32'h201);
    check("t3_head_addr", 32'(addr0), 32'd0);
    check("t3_ovf", 32'(ovf0), 32'd1);
    ready0 = 1'b1;
    wait_clk(10);
    check("t3_count", 32'(q0d.size()), 32'd4);
    expect_entry("t3", 0, 0, 32'h201, 32'd0);
    expect_entry("t3", 0, 1, 32'h030, 32'd1);
    expect_entry("t3", 0, 2, 32'h504, 32'd2);
    expect_entry("t3", 0, 3, 32'h060, 32'd3);
    check("t3_drained", 32'(valid0), 32'd0);
    check("t3_ovf_sticky", 32'(ovf0), 32'd1);

    // Test 4: partial byte at frame end, then a fresh frame
    clear_q0();
    cs_set(0, 1'b0);
    check("t4_ovf_cleared", 32'(ovf0), 32'd0);
    send_byte(0, 8'h21); send_byte(0, 8'h43);
    spi_bits(0, 8'h65, 3);
    cs_set(0, 1'b1);
    wait_clk(20);
    cs_set(0, 1'b0);
    send_byte(0, 8'hAA); send_byte(0, 8'h0B);
    cs_set(0, 1'b1);
    wait_clk(20);
    check("t4_count", 32'(q0d.size()), 32'd2);
    expect_entry("t4", 0, 0, 32'h321, 32'd0);
    expect_entry("t4", 0, 1, 32'hBAA, 32'd0);

    // Test 5: reset mid-byte with cs_n low; edges ignored until next frame
    clear_q0();
    cs_set(0, 1'b0);
    spi_bits(0, 8'h21, 4);
    rstn = 1'b0;
    wait_clk(3);
    rstn = 1'b1;
    wait_clk(4);
    spi_bits(0, 8'h10, 4);
    send_byte(0, 8'h43); send_byte(0, 8'h65);
    cs_set(0, 1'b1);
    wait_clk(20);
    check("t5_no_output", 32'(q0d.size()), 32'd0);
    check("t5_valid", 32'(valid0), 32'd0);
    cs_set(0, 1'b0);
    send_byte(0, 8'h21); send_byte(0, 8'h43);
    cs_set(0, 1'b1);
    wait_clk(20);
    check("t5_count", 32'(q0d.size()), 32'd1);
    expect_entry("t5", 0, 0, 32'h321, 32'd0);

    // Test 6: push and pop in the same cycle on a full FIFO
    clear_q0();
    ready0 = 1'b0;
    cs_set(0, 1'b0);
    for (int b = 1; b <= 6; b++) send_byte(0, 8'(b));
    wait_clk(10);
    seen = 1'b0;
    fork
      begin
        send_byte(0, 8'h07);
        send_byte(0, 8'h08);
      end
      begin
        for (int i = 0; i < 4000 && !seen; i++) begin
          @(negedge clk);
          if (dut0.push_r) begin
            seen = 1'b1;
            ready0 = 1'b1;
            @(negedge clk);
            ready0 = 1'b0;
          end
        end
      end
    join
    check("t6_push_seen", 32'(seen), 32'd1);
    cs_set(0, 1'b1);
    wait_clk(5);
    check("t6_ovf", 32'(ovf0), 32'd0);
    ready0 = 1'b1;
    wait_clk(10);
    check("t6_count", 32'(q0d.size()), 32'd5);
    expect_entry("t6", 0, 0, 32'h201, 32'd0);
    expect_entry("t6", 0, 1, 32'h030, 32'd1);
    expect_entry("t6", 0, 2, 32'h504, 32'd2);
    expect_entry("t6", 0, 3, 32'h060, 32'd3);
    expect_entry("t6", 0, 4, 32'h807, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
